// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Fetch-side branch predictor for the pipelined TSC CPU.
// - The direct-mapped BTB has 2^BTB_INDEX_BITS entries. Each entry holds:
//   valid, tag, target, a 2-bit saturating counter and an is_jump flag.
// - Each cycle it supplies a predicted next PC to IF.
// - It resolves control-flow instructions in ID and flags mispredictions.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   stall                pipeline stalled: no resolution, no training
//   pc_IF                PC being fetched
//   predicted_pc         predicted next PC (combinational)
//   resolve_*            ID-stage control-flow instruction being resolved
//   jump_miss            unconditional jump was mispredicted
//   i_branch_miss        conditional branch was mispredicted
//   correct_pc           redirect target on a miss
//   branch_count         resolved control-flow instructions since reset
//   miss_count           mispredictions since reset
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int BTB_INDEX_BITS = 8,
    parameter int WORD_SIZE      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [WORD_SIZE-1:0] pc_IF,
    output logic [WORD_SIZE-1:0] predicted_pc,
    input  logic                 resolve_valid,
    input  logic                 resolve_is_branch,
    input  logic                 resolve_is_jump,
    input  logic [WORD_SIZE-1:0] resolve_pc,
    input  logic                 resolve_taken,
    input  logic [WORD_SIZE-1:0] resolve_target,
    input  logic [WORD_SIZE-1:0] resolve_pred_pc,
    output logic                 jump_miss,
    output logic                 i_branch_miss,
    output logic [WORD_SIZE-1:0] correct_pc,
    output logic [15:0]          branch_count,
    output logic [15:0]          miss_count
);

    localparam int ENTRIES = 1 << BTB_INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - BTB_INDEX_BITS;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     tag;
        logic [WORD_SIZE-1:0] target;
        logic [1:0]           ctr;
        logic                 is_jump;
    } entry_t;

    // Saturating 2-bit counter step: 11 holds on taken, 00 holds on not-taken.
    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up && c != 2'b11) r = c + 2'b01;
        else if (!up && c != 2'b00) r = c - 2'b01;
        return r;
    endfunction

    entry_t btb_q [ENTRIES];
    logic [15:0] branch_count_q, branch_count_d;
    logic [15:0] miss_count_q,   miss_count_d;

    // ---------------- prediction ----------------
    logic [BTB_INDEX_BITS-1:0] lk_idx;
    logic                      lk_hit;

    always_comb begin
        lk_idx = pc_IF[BTB_INDEX_BITS-1:0];
        lk_hit = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == pc_IF[WORD_SIZE-1:BTB_INDEX_BITS]);
        predicted_pc = pc_IF + WORD_SIZE'(1);
        if (lk_hit && (btb_q[lk_idx].is_jump || btb_q[lk_idx].ctr[1]))
            predicted_pc = btb_q[lk_idx].target;
    end

    // ---------------- resolution ----------------
    logic                      active;
    logic                      miss;
    logic [WORD_SIZE-1:0]      actual_pc;
    logic [BTB_INDEX_BITS-1:0] rs_idx;
    logic [TAG_W-1:0]          rs_tag;
    entry_t                    rs_entry;
    logic                      rs_hit;

    always_comb begin
        active    = resolve_valid && !stall && (resolve_is_branch || resolve_is_jump);
        // A jump is always taken, even when is_branch is also set.
        actual_pc = (resolve_is_jump || resolve_taken) ? resolve_target
                                                       : resolve_pc + WORD_SIZE'(1);
        miss          = active && (actual_pc != resolve_pred_pc);
        jump_miss     = miss && resolve_is_jump;
        i_branch_miss = miss && resolve_is_branch && !resolve_is_jump;
        correct_pc    = actual_pc;
        rs_idx   = resolve_pc[BTB_INDEX_BITS-1:0];
        rs_tag   = resolve_pc[WORD_SIZE-1:BTB_INDEX_BITS];
        rs_entry = btb_q[rs_idx];
        rs_hit   = rs_entry.valid && (rs_entry.tag == rs_tag);
    end

    // ---------------- training ----------------
    logic   upd_en;
    entry_t entry_d;

    always_comb begin
        upd_en  = 1'b0;
        entry_d = rs_entry;
        if (active) begin
            if (resolve_is_jump) begin
                upd_en          = 1'b1;
                entry_d.valid   = 1'b1;
                entry_d.tag     = rs_tag;
                entry_d.target  = resolve_target;
                entry_d.ctr     = 2'b11;
                entry_d.is_jump = 1'b1;
            end else if (rs_hit) begin
                upd_en      = 1'b1;
                entry_d.ctr = sat_ctr(rs_entry.ctr, resolve_taken);
                if (resolve_taken) entry_d.target = resolve_target;
            end else if (resolve_taken) begin
                // Allocate on first taken; replaces any aliased entry.
                upd_en          = 1'b1;
                entry_d.valid   = 1'b1;
                entry_d.tag     = rs_tag;
                entry_d.target  = resolve_target;
                entry_d.ctr     = 2'b10;
                entry_d.is_jump = 1'b0;
            end
        end
        branch_count_d = branch_count_q + {15'b0, active};
        miss_count_d   = miss_count_q + {15'b0, miss};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i].valid <= 1'b0;
                btb_q[i].ctr   <= 2'b01;
            end
            branch_count_q <= '0;
            miss_count_q   <= '0;
        end else begin
            if (upd_en) btb_q[rs_idx] <= entry_d;
            branch_count_q <= branch_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign branch_count = branch_count_q;
    assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [15:0] pc_IF = 16'h0010;
    logic [15:0] predicted_pc;
    logic        resolve_valid = 1'b0;
    logic        resolve_is_branch = 1'b0;
    logic        resolve_is_jump = 1'b0;
    logic [15:0] resolve_pc = '0;
    logic        resolve_taken = 1'b0;
    logic [15:0] resolve_target = '0;
    logic [15:0] resolve_pred_pc = '0;
    logic        jump_miss, i_branch_miss;
    logic [15:0] correct_pc, branch_count, miss_count;

    branch_predictor #(.BTB_INDEX_BITS(8), .WORD_SIZE(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_IF(pc_IF),
        .predicted_pc(predicted_pc),
        .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
        .resolve_is_jump(resolve_is_jump), .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .resolve_pred_pc(resolve_pred_pc),
        .jump_miss(jump_miss), .i_branch_miss(i_branch_miss),
        .correct_pc(correct_pc), .branch_count(branch_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] ppc;
        logic        jm;
        logic        bm;
        logic        chk_cpc;
        logic [15:0] cpc;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   step_id = 0;

    task automatic cmp(input string name, input int id, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%04h required=0x%04h", name, id, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so one expectation is consumed per
    // checked cycle, mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp("predicted_pc",  e.id, predicted_pc,           e.ppc);
            cmp("jump_miss",     e.id, {15'b0, jump_miss},     {15'b0, e.jm});
            cmp("i_branch_miss", e.id, {15'b0, i_branch_miss}, {15'b0, e.bm});
            if (e.chk_cpc) cmp("correct_pc", e.id, correct_pc, e.cpc);
            cmp("branch_count",  e.id, branch_count,           e.bc);
            cmp("miss_count",    e.id, miss_count,             e.mc);
        end
    end

    // One clock cycle of stimulus; optionally queue the expected outputs.
    task automatic cyc(input logic r, input logic s, input logic v, input logic b, input logic j,
                       input logic [15:0] rpc, input logic tk, input logic [15:0] tgt,
                       input logic [15:0] pred, input logic [15:0] pcif, input logic chk,
                       input logic [15:0] e_ppc, input logic e_jm, input logic e_bm,
                       input logic [15:0] e_cpc, input logic [15:0] e_bc, input logic [15:0] e_mc);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; stall = s; resolve_valid = v; resolve_is_branch = b; resolve_is_jump = j;
        resolve_pc = rpc; resolve_taken = tk; resolve_target = tgt; resolve_pred_pc = pred;
        pc_IF = pcif;
        step_id++;
        if (chk) begin
            e.id = step_id; e.ppc = e_ppc; e.jm = e_jm; e.bm = e_bm;
            e.chk_cpc = v && (b || j); e.cpc = e_cpc; e.bc = e_bc; e.mc = e_mc;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input logic [15:0] pcif, input logic [15:0] e_ppc,
                        input logic [15:0] e_bc, input logic [15:0] e_mc);
        cyc(0, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0, pcif, 1, e_ppc, 0, 0, 16'h0, e_bc, e_mc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", step_id);
        $fatal(1, "timeout");
    end

    initial begin
        // args: r s v b j rpc tk tgt pred pcif chk | ppc jm bm cpc bc mc
        cyc(1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0010, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        cyc(1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0010, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        // reset state
        idle(16'h0010, 16'h0011, 0, 0);
        // JMP 0x0010 -> 0x0040, predicted fall-through: jump miss
        cyc(0, 0, 1, 0, 1, 16'h0010, 0, 16'h0040, 16'h0011, 16'h0010, 1, 16'h0011, 1, 0, 16'h0040, 0, 0);
        idle(16'h0010, 16'h0040, 1, 1);
        // BEQ 0x0020 -> 0x0005 training
        idle(16'h0020, 16'h0021, 1, 1);
        cyc(0, 0, 1, 1, 0, 16'h0020, 1, 16'h0005, 16'h0021, 16'h0020, 1, 16'h0021, 0, 1, 16'h0005, 1, 1);
        idle(16'h0020, 16'h0005, 2, 2);
        cyc(0, 0, 1, 1, 0, 16'h0020, 1, 16'h0005, 16'h0005, 16'h0020, 1, 16'h0005, 0, 0, 16'h0005, 2, 2);
        cyc(0, 0, 1, 1, 0, 16'h0020, 1, 16'h0005, 16'h0005, 16'h0020, 1, 16'h0005, 0, 0, 16'h0005, 3, 2);
        cyc(0, 0, 1, 1, 0, 16'h0020, 1, 16'h0005, 16'h0005, 16'h0020, 1, 16'h0005, 0, 0, 16'h0005, 4, 2);
        // not taken twice: 11 -> 10 -> 01
        cyc(0, 0, 1, 1, 0, 16'h0020, 0, 16'h0005, 16'h0005, 16'h0020, 1, 16'h0005, 0, 1, 16'h0021, 5, 2);
        idle(16'h0020, 16'h0005, 6, 3);
        cyc(0, 0, 1, 1, 0, 16'h0020, 0, 16'h0005, 16'h0005, 16'h0020, 1, 16'h0005, 0, 1, 16'h0021, 6, 3);
        idle(16'h0020, 16'h0021, 7, 4);
        // stalled resolve for 3 cycles, then release
        cyc(0, 1, 1, 1, 0, 16'h0030, 1, 16'h0050, 16'h0031, 16'h0030, 1, 16'h0031, 0, 0, 16'h0050, 7, 4);
        cyc(0, 1, 1, 1, 0, 16'h0030, 1, 16'h0050, 16'h0031, 16'h0030, 1, 16'h0031, 0, 0, 16'h0050, 7, 4);
        cyc(0, 1, 1, 1, 0, 16'h0030, 1, 16'h0050, 16'h0031, 16'h0030, 1, 16'h0031, 0, 0, 16'h0050, 7, 4);
        cyc(0, 0, 1, 1, 0, 16'h0030, 1, 16'h0050, 16'h0031, 16'h0030, 1, 16'h0031, 0, 1, 16'h0050, 7, 4);
        idle(16'h0030, 16'h0050, 8, 5);
        // aliasing at index 0x05
        cyc(0, 0, 1, 1, 0, 16'h0105, 1, 16'h0111, 16'h0106, 16'h0105, 1, 16'h0106, 0, 1, 16'h0111, 8, 5);
        idle(16'h0105, 16'h0111, 9, 6);
        cyc(0, 0, 1, 1, 0, 16'h0205, 1, 16'h0222, 16'h0206, 16'h0205, 1, 16'h0206, 0, 1, 16'h0222, 9, 6);
        idle(16'h0105, 16'h0106, 10, 7);
        idle(16'h0205, 16'h0222, 10, 7);
        // correctly predicted jump: no miss
        cyc(0, 0, 1, 0, 1, 16'h0010, 0, 16'h0040, 16'h0040, 16'h0010, 1, 16'h0040, 0, 0, 16'h0040, 10, 7);
        // branch+jump both set behaves as jump (taken despite taken=0)
        cyc(0, 0, 1, 1, 1, 16'h0060, 0, 16'h0070, 16'h0061, 16'h0060, 1, 16'h0061, 1, 0, 16'h0070, 11, 7);
        idle(16'h0060, 16'h0070, 12, 8);
        // invalid ID slot: no miss, no count
        cyc(0, 0, 0, 1, 0, 16'h0090, 1, 16'h0099, 16'h0000, 16'h0090, 1, 16'h0091, 0, 0, 16'h0000, 12, 8);
        idle(16'h0090, 16'h0091, 12, 8);
        // reset in a missing resolve cycle
        cyc(1, 0, 1, 0, 1, 16'h0080, 0, 16'h0099, 16'h0081, 16'h0080, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        idle(16'h0010, 16'h0011, 0, 0);
        idle(16'h0080, 16'h0081, 0, 0);
        idle(16'hFFFF, 16'h0000, 0, 0);
        idle(16'h0020, 16'h0021, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor for the pipelined TSC CPU.
- Supplies the predicted next PC to IF every cycle and resolves control-flow instructions in ID.
- Drives the misprediction signals (jump_miss, i_branch_miss) consumed by the hazard control unit, plus the corrected PC for redirect.
- Direct-mapped BTB with per-entry 2-bit saturating counters.

Parameters:
BTB_INDEX_BITS, 8, index width; BTB holds 2^BTB_INDEX_BITS entries indexed by PC[BTB_INDEX_BITS-1:0]
WORD_SIZE, 16, PC / target width in bits

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  pipeline stalled (pc_write low); freezes resolution and updates
pc_IF  input  WORD_SIZE  PC of instruction being fetched
predicted_pc  output  WORD_SIZE  predicted next PC for IF (combinational from pc_IF and table)
resolve_valid  input  1  ID holds a valid (non-flushed) instruction
resolve_is_branch  input  1  ID instruction is BNE/BEQ/BGZ/BLZ
resolve_is_jump  input  1  ID instruction is JMP/JAL/JPR/JRL
resolve_pc  input  WORD_SIZE  PC of ID instruction
resolve_taken  input  1  actual branch outcome (ignored for jumps, treated as 1)
resolve_target  input  WORD_SIZE  actual taken target
resolve_pred_pc  input  WORD_SIZE  predicted_pc captured when that instruction was in IF
jump_miss  output  1  unconditional jump mispredicted
i_branch_miss  output  1  conditional branch mispredicted
correct_pc  output  WORD_SIZE  PC to redirect fetch to on a miss
branch_count  output  16  resolved control-flow instructions since reset
miss_count  output  16  mispredictions since reset

Behaviour:
- Entry fields: valid, tag = PC[WORD_SIZE-1:BTB_INDEX_BITS], target, ctr[1:0], is_jump.
- Reset (synchronous, overrides everything that cycle): all valid=0, ctr=2'b01, branch_count=0, miss_count=0.
  - Miss outputs are combinational and 0 whenever resolve_valid=0.
  - predicted_pc after reset = pc_IF+1.
- Prediction (combinational): hit = valid && tag match at index(pc_IF).
  - predicted_pc = target when hit && (is_jump || ctr[1]); else pc_IF+1 (word-addressed, wraps 0xFFFF->0x0000).
- Resolution (combinational), active = resolve_valid && !stall && (resolve_is_branch || resolve_is_jump):
  - actual = (is_jump || resolve_taken) ? resolve_target : resolve_pc+1.
  - miss = active && actual != resolve_pred_pc.
  - jump_miss = miss && resolve_is_jump.
  - i_branch_miss = miss && resolve_is_branch && !resolve_is_jump.
  - correct_pc = actual, driven always; meaningful only on a miss.
  - is_branch and is_jump both high: treat as jump.
- Update at clock edge when active (index/tag from resolve_pc):
  - Jump: write valid=1, tag, target, is_jump=1, ctr=2'b11.
  - Branch, entry hit: ctr saturating +1 if taken / -1 if not taken (11 and 00 hold); target rewritten if taken.
  - Branch, no hit, taken: allocate/replace with ctr=2'b10, is_jump=0.
  - Branch, no hit, not taken: no allocation.
  - branch_count += 1; miss_count += miss. Both wrap modulo 2^16.
- Stall: no table update, no counter update, miss outputs 0. The held instruction resolves once after stall releases; no double counting.
- Same-cycle lookup and update at the same index: lookup sees pre-update contents (no bypass); the new entry is visible next cycle.
- Latency: prediction 0 cycles; training visible 1 cycle after the resolve edge.

Test Plan:
- Reset, pc_IF=0x0010 -> predicted_pc=0x0011, jump_miss=i_branch_miss=0, counts 0.
- Resolve JMP pc=0x0010 target=0x0040 pred=0x0011 -> jump_miss=1, correct_pc=0x0040 that cycle; next cycle pc_IF=0x0010 -> predicted_pc=0x0040.
- BEQ pc=0x0020 taken target=0x0005, four times with correct prior predictions fed back:
  - First resolve -> miss, ctr=10.
  - Later resolves -> ctr 11, predicted_pc 0x0005, no miss.
  - Then not taken twice -> ctr 01 and predicted_pc=0x0021; first not-taken resolve misses with correct_pc=0x0021.
- Resolve pending with stall=1 for 3 cycles, then stall=0 -> miss/update only in the release cycle; branch_count increments by exactly 1.
- Aliasing: pc=0x0105 and 0x0205 (BTB_INDEX_BITS=8), both taken -> second replaces first; lookup of 0x0105 then predicts 0x0106.
- Reset asserted in a resolve cycle with miss condition -> all entries invalid and counts 0 next cycle; pc_IF=0xFFFF predicts 0x0000.
